// File: rtl/t_param_store.sv
// Per-pixel store for the PBAS learning rate T: written from the (tnv, tnx) stream, read back on the next frame.
// Optional feature: define T_ERR_FIX_EN to store 16'hffff writes as T_INIT and count them on err_cnt.
module t_param_store #(
  parameter int                DATA_W = 16,
  parameter int                ADDR_W = 10,
  parameter int                NPIX   = 1024,
  parameter logic [DATA_W-1:0] T_INIT = 16'd18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sof,
  input  logic              pv,
  output logic              tv,
  output logic [DATA_W-1:0] tx,
  input  logic              tn_sof,
  input  logic              tnv,
  input  logic [DATA_W-1:0] tnx,
  output logic              frm_err
`ifdef T_ERR_FIX_EN
  ,
  output logic [15:0]       err_cnt
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [DATA_W-1:0] T_ERR     = '1;

  logic [DATA_W-1:0] mem [NPIX];

  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_sel;
  logic [ADDR_W-1:0] wr_sel;
  logic              init_rd;
  logic              init_rd_eff;
  logic              frame_done;
  logic [DATA_W-1:0] wr_data;

  // A sof restarts the pixel count and re-decides whether a full frame exists to read.
  always_comb begin
    rd_sel      = sof ? '0 : rd_addr;
    wr_sel      = tn_sof ? '0 : wr_addr;
    init_rd_eff = sof ? ~frame_done : init_rd;
`ifdef T_ERR_FIX_EN
    wr_data     = (tnx == T_ERR) ? T_INIT : tnx;
`else
    wr_data     = tnx;
`endif
  end

  // NOTE: the storage array has no reset; T_INIT is substituted on read until a frame completes.
  always_ff @(posedge clk) begin
    if (tnv) mem[wr_sel] <= wr_data;
  end

  // NOTE: state registers use non-blocking assignments so the old mem word is read on a same-address write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tv      <= 1'b0;
      tx      <= '0;
      rd_addr <= '0;
      init_rd <= 1'b1;
    end else begin
      tv <= pv;
      if (pv) begin
        tx      <= init_rd_eff ? T_INIT : mem[rd_sel];
        rd_addr <= (rd_sel == LAST_ADDR) ? '0 : rd_sel + 1'b1;
        if (sof) init_rd <= ~frame_done;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr    <= '0;
      frame_done <= 1'b0;
      frm_err    <= 1'b0;
    end else if (tnv) begin
      wr_addr <= (wr_sel == LAST_ADDR) ? '0 : wr_sel + 1'b1;
      if (wr_sel == LAST_ADDR) frame_done <= 1'b1;
      // Short frame, or a new frame that arrived without its sof marker.
      if ((tn_sof && wr_addr != '0) || (!tn_sof && wr_addr == '0 && frame_done))
        frm_err <= 1'b1;
    end
  end

`ifdef T_ERR_FIX_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (tnv && tnx == T_ERR && err_cnt != 16'hffff) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_t_param_store.sv
// Scoreboard bench for t_param_store with an 8-pixel frame; expected T values are queued as reads are issued.
module tb_t_param_store;

  localparam int          DATA_W = 16;
  localparam int          ADDR_W = 3;
  localparam int          NPIX   = 8;
  localparam logic [15:0] T_INIT = 16'd18;

  logic              clk = 1'b0;
  logic              rst;
  logic              sof, pv, tn_sof, tnv;
  logic [DATA_W-1:0] tnx;
  logic              tv;
  logic [DATA_W-1:0] tx;
  logic              frm_err;
`ifdef T_ERR_FIX_EN
  logic [15:0]       err_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic pv_prev = 1'b0;

  t_param_store #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NPIX(NPIX), .T_INIT(T_INIT)) dut (
    .clk(clk), .rst(rst), .sof(sof), .pv(pv), .tv(tv), .tx(tx),
    .tn_sof(tn_sof), .tnv(tnv), .tnx(tnx), .frm_err(frm_err)
`ifdef T_ERR_FIX_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Sample away from the rising edge: tv must echo last cycle's pv, and each tv pops one expected T.
  always @(negedge clk) begin
    check("tv_latency", tv, pv_prev);
    if (tv) begin
      if (exp_q.size() == 0) check("tx_unexpected", 1'b1, 1'b0);
      else check("tx", tx, exp_q.pop_front());
    end
    pv_prev = rst ? 1'b0 : pv;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_px(input logic s, input logic [DATA_W-1:0] e);
    pv = 1'b1; sof = s;
    exp_q.push_back(e);
    tick();
    pv = 1'b0; sof = 1'b0;
  endtask

  task automatic write_px(input logic s, input logic [DATA_W-1:0] v);
    tnv = 1'b1; tn_sof = s; tnx = v;
    tick();
    tnv = 1'b0; tn_sof = 1'b0;
  endtask

  task automatic drain();
    repeat (3) tick();
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] px2;
    rst = 1'b1; sof = 0; pv = 0; tn_sof = 0; tnv = 0; tnx = '0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("rst_tv", tv, 0);
    check("rst_tx", tx, 0);
    check("rst_frm_err", frm_err, 0);

    // 1: nothing stored yet, every read returns T_INIT
    for (int i = 0; i < NPIX; i++) read_px(i == 0, T_INIT);
    drain();
    check("t1_frm_err", frm_err, 0);

    // 2: store 100..107 and read it back
    for (int i = 0; i < NPIX; i++) write_px(i == 0, 16'(100 + i));
    for (int i = 0; i < NPIX; i++) read_px(i == 0, 16'(100 + i));
    drain();

    // 3: two passes, the second without sof, relies on the read address wrap
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < NPIX; i++) read_px(p == 0 && i == 0, 16'(100 + i));
    drain();

    // 4: short frame of 5 then an early sof writing 55 at pixel 0
    for (int i = 0; i < 5; i++) write_px(i == 0, 16'(200 + i));
    check("t4_no_err_yet", frm_err, 0);
    write_px(1'b1, 16'd55);
    check("t4_frm_err", frm_err, 1);
    for (int i = 0; i < NPIX; i++)
      read_px(i == 0, (i == 0) ? 16'd55 : (i < 5) ? 16'(200 + i) : 16'(100 + i));
    drain();

    // 5: reset in the middle of a write at pixel 3
    for (int i = 0; i < 3; i++) write_px(i == 0, 16'(300 + i));
    tnv = 1'b1; tnx = 16'd303;
    #2 rst = 1'b1;
    #1;
    check("t5_tv", tv, 0);
    check("t5_tx", tx, 0);
    check("t5_frm_err", frm_err, 0);
    tick();
    tnv = 1'b0;
    rst = 1'b0;
    tick();
    for (int i = 0; i < NPIX; i++) read_px(i == 0, T_INIT);
    drain();
    check("t5_frm_err_after", frm_err, 0);

    // 6: an error code at pixel 2
`ifdef T_ERR_FIX_EN
    px2 = T_INIT;
`else
    px2 = 16'hffff;
`endif
    for (int i = 0; i < NPIX; i++) write_px(i == 0, (i == 2) ? 16'hffff : 16'(400 + i));
    for (int i = 0; i < NPIX; i++) read_px(i == 0, (i == 2) ? px2 : 16'(400 + i));
    drain();
`ifdef T_ERR_FIX_EN
    check("t6_err_cnt", err_cnt, 1);
`endif
    check("t6_frm_err", frm_err, 0);

    // 7: a full frame followed by a write with no sof flags a missing sof, still lands on pixel 0
    write_px(1'b0, 16'd77);
    check("t7_frm_err", frm_err, 1);
    for (int i = 0; i < NPIX; i++)
      read_px(i == 0, (i == 0) ? 16'd77 : (i == 2) ? px2 : 16'(400 + i));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
